// File: rtl/swi_conditioner.sv
// swi_conditioner: 2-flop synchroniser, per-bit debounce and edge pulses for the slide switches.
// Latency: a held raw level reaches swi_out DEBOUNCE_CYCLES+1 edges after the edge that first captures it.
// No backpressure: free-running, one evaluation per clk_2 edge. Optional toggle outputs: SWI_CONDITIONER_TOGGLE_EN.
module swi_conditioner #(
  parameter int NBITS           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] swi_raw,
  output logic [NBITS-1:0] swi_out,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic             any_change,
  output logic [NBITS-1:0] swi_toggle
);

  // Counter width follows from the debounce length; it only ever counts up to DEBOUNCE_CYCLES-1.
  localparam int                  CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0]    r_sync1;
  logic [NBITS-1:0]    r_sync2;
  logic [NBITS-1:0]    r_out;
  logic [NBITS-1:0]    r_rise;
  logic [NBITS-1:0]    r_fall;
  logic                r_any;
  logic [CNT_BITS-1:0] r_cnt [NBITS];

  logic [NBITS-1:0]    w_differs;
  logic [NBITS-1:0]    w_accept;
  logic [NBITS-1:0]    w_rise;
  logic [NBITS-1:0]    w_fall;
  logic [CNT_BITS-1:0] w_cnt_nxt [NBITS];

  // Per-bit debounce decision: a bit flips only after DEBOUNCE_CYCLES consecutive differing edges.
  always_comb begin
    w_differs = r_sync2 ^ r_out;
    w_accept  = '0;
    for (int i = 0; i < NBITS; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_differs[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_accept[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_BITS'(1);
        end
      end
    end
    w_rise = w_accept & r_sync2;
    w_fall = w_accept & ~r_sync2;
  end

  // Plain two-flop synchroniser; nothing may sit between the stages.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= swi_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level, registered pulses aligned with the level change, and the counters.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
      for (int i = 0; i < NBITS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_out  <= r_out ^ w_accept;
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_any  <= |w_accept;
      for (int i = 0; i < NBITS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

`ifdef SWI_CONDITIONER_TOGGLE_EN
  logic [NBITS-1:0] r_toggle;

  // Push-on/push-off state: flips the edge after each rise pulse.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_toggle <= '0;
    end else begin
      r_toggle <= r_toggle ^ r_rise;
    end
  end

  assign swi_toggle = r_toggle;
`else
  assign swi_toggle = '0;
`endif

  assign swi_out    = r_out;
  assign swi_rise   = r_rise;
  assign swi_fall   = r_fall;
  assign any_change = r_any;

endmodule

// File: tb/tb_swi_conditioner.sv
// Bench for swi_conditioner: DEBOUNCE_CYCLES=4 and =1 instances driven from the same switches.
// Reference model judges each bit by a window over the synchronised history.
// Directed test-plan sequences followed by randomized hold/reset stimulus.
module tb_swi_conditioner;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [7:0] swi_raw;

  logic [7:0] out4, rise4, fall4, tog4;
  logic [7:0] out1, rise1, fall1, tog1;
  logic       any4, any1;

  int tests = 0;
  int fails = 0;

  always #5 clk_2 = ~clk_2;

  swi_conditioner #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk_2(clk_2), .reset(reset), .swi_raw(swi_raw),
    .swi_out(out4), .swi_rise(rise4), .swi_fall(fall4),
    .any_change(any4), .swi_toggle(tog4)
  );

  swi_conditioner #(.NBITS(8), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk_2(clk_2), .reset(reset), .swi_raw(swi_raw),
    .swi_out(out1), .swi_rise(rise1), .swi_fall(fall1),
    .any_change(any1), .swi_toggle(tog1)
  );

  // Reference model state, index 0 = DEBOUNCE_CYCLES 4, index 1 = DEBOUNCE_CYCLES 1.
  int         dcs [2] = '{4, 1};
  logic [7:0] pipe  [2][2];   // [0] = value seen by the debouncer, [1] = first sync stage
  logic [7:0] hist  [2][16];  // synchronised history, [0] most recent
  int         hcnt  [2];
  logic [7:0] m_out [2];
  logic [7:0] m_rise[2];
  logic [7:0] m_fall[2];
  logic [7:0] m_tog [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [7:0] raw);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        pipe[m][0] = '0; pipe[m][1] = '0;
        hcnt[m] = 0;
        m_out[m] = '0; m_rise[m] = '0; m_fall[m] = '0; m_tog[m] = '0;
      end else begin
        logic [7:0] nxt;
        for (int j = 15; j > 0; j--) hist[m][j] = hist[m][j-1];
        hist[m][0] = pipe[m][0];
        if (hcnt[m] < 16) hcnt[m]++;
        nxt = m_out[m];
        for (int i = 0; i < 8; i++) begin
          if (hcnt[m] >= dcs[m]) begin
            bit all_diff = 1'b1;
            for (int j = 0; j < dcs[m]; j++)
              if (hist[m][j][i] == m_out[m][i]) all_diff = 1'b0;
            if (all_diff) nxt[i] = ~m_out[m][i];
          end
        end
        m_tog[m]  = m_tog[m] ^ m_rise[m];
        m_rise[m] = nxt & ~m_out[m];
        m_fall[m] = ~nxt & m_out[m];
        m_out[m]  = nxt;
        pipe[m][0] = pipe[m][1];
        pipe[m][1] = raw;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] raw);
    logic [7:0] et0, et1;
    reset   = rst;
    swi_raw = raw;
    @(posedge clk_2);
    model_edge(rst, raw);
    #1;
`ifdef SWI_CONDITIONER_TOGGLE_EN
    et0 = m_tog[0]; et1 = m_tog[1];
`else
    et0 = 8'h00; et1 = 8'h00;
`endif
    check("out4",  out4,  m_out[0]);
    check("rise4", rise4, m_rise[0]);
    check("fall4", fall4, m_fall[0]);
    check("any4",  {7'b0, any4}, {7'b0, |(m_rise[0] | m_fall[0])});
    check("tog4",  tog4,  et0);
    check("out1",  out1,  m_out[1]);
    check("rise1", rise1, m_rise[1]);
    check("fall1", fall1, m_fall[1]);
    check("any1",  {7'b0, any1}, {7'b0, |(m_rise[1] | m_fall[1])});
    check("tog1",  tog1,  et1);
  endtask

  initial begin
    logic [7:0] r;
    int         hold;
    reset = 1'b1;
    swi_raw = 8'hFF;

    // Reset held 3 cycles with all switches high, then released: rise at the 6th edge.
    repeat (3) step(1'b1, 8'hFF);
    check("rst_out4", out4, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 8'hFF);
      check("tp1_out4",  out4,  (k == 6) ? 8'hFF : 8'h00);
      check("tp1_rise4", rise4, (k == 6) ? 8'hFF : 8'h00);
      check("tp1_any4",  {7'b0, any4}, (k == 6) ? 8'h01 : 8'h00);
    end
    step(1'b0, 8'hFF);
    check("tp1_rise4_once", rise4, 8'h00);

    // Settle low, then a 3-cycle glitch on bit 3 must not reach the 4-cycle instance.
    repeat (8) step(1'b0, 8'h00);
    repeat (3) step(1'b0, 8'h08);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 8'h00);
      check("tp2_out4", out4, 8'h00);
      check("tp2_any4", {7'b0, any4}, 8'h00);
    end

    // 0F -> F0 swaps in one step with rise and fall pulses together.
    repeat (8) step(1'b0, 8'h0F);
    check("tp3_pre", out4, 8'h0F);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 8'hF0);
      check("tp3_out4", out4, (k == 6) ? 8'hF0 : 8'h0F);
    end
    check("tp3_rise4", rise4, 8'hF0);
    check("tp3_fall4", fall4, 8'h0F);
    check("tp3_any4",  {7'b0, any4}, 8'h01);

    // Reset on the 4th edge after bit 0 rises, then a rise 6 edges after release.
    repeat (8) step(1'b0, 8'h00);
    repeat (3) step(1'b0, 8'h01);
    step(1'b1, 8'h01);
    check("tp4_rst_out4", out4, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 8'h01);
      check("tp4_out4",  out4,  (k == 6) ? 8'h01 : 8'h00);
      check("tp4_rise4", rise4, (k == 6) ? 8'h01 : 8'h00);
    end

    // Single-cycle debounce: 3-edge latency on bit 7 in both directions.
    repeat (8) step(1'b0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 8'h80);
      check("tp5_out1", out1, (k == 3) ? 8'h80 : 8'h00);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 8'h00);
      check("tp5_fall1", fall1, (k == 3) ? 8'h80 : 8'h00);
    end

    // Three presses on bit 2: toggle 1,0,1 when enabled, always 0 otherwise.
    repeat (8) step(1'b0, 8'h00);
    for (int p = 0; p < 3; p++) begin
      repeat (8) step(1'b0, 8'h04);
      repeat (8) step(1'b0, 8'h00);
`ifdef SWI_CONDITIONER_TOGGLE_EN
      check("tp6_tog4", tog4, (p % 2 == 0) ? 8'h04 : 8'h00);
`else
      check("tp6_tog4", tog4, 8'h00);
`endif
    end

    // Randomized holds of 1..8 cycles with occasional resets.
    r = 8'h00;
    for (int n = 0; n < 600; n++) begin
      r    = r ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++)
        step(($urandom_range(0, 199) == 0), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
